// File: rtl/eth_ping_pkg.sv
// Shared constants, frame field offsets and FSM state types for the ping responder.
package eth_ping_pkg;

  localparam logic [31:0] PING_MAGIC = 32'h50494E47;  // "PING"
  localparam logic [31:0] PONG_MAGIC = 32'h504F4E47;  // "PONG"
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  // Byte offsets of the fields inside a ping/pong frame
  localparam int OFF_DST   = 0;
  localparam int OFF_SRC   = 6;
  localparam int OFF_TYPE  = 12;
  localparam int OFF_MAGIC = 14;
  localparam int OFF_ID    = 18;
  localparam int OFF_TS    = 22;
  localparam int HDR_LEN   = 30;

  typedef enum logic [1:0] {RX_HDR, RX_SKIP, RX_TAIL} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // Byte 'pos' (0 = most significant) of the low 'nbytes' bytes of 'word'
  function automatic logic [7:0] field_byte(input logic [63:0] word, input int nbytes,
                                            input int pos);
    logic [63:0] sh;
    sh = word >> (8 * (nbytes - 1 - pos));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/eth_ping_parser.sv
// RX side: walks the 30-byte ping header on the fly, latches src MAC / id / timestamp
// and pulses ping_valid in the same cycle as the accepted tlast of a matching frame.
module eth_ping_parser
  import eth_ping_pkg::*;
#(
  parameter logic [15:0] C_ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] own_mac,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        ping_valid,
  output logic [47:0] ping_src,
  output logic [31:0] ping_id,
  output logic [63:0] ping_ts
);

  rx_state_t   state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  int          rx_pos;
  logic        beat, fin, last_hdr, byte_ok;
  logic        own_ok, bc_ok, own_ok_nxt, bc_ok_nxt;
  logic [47:0] src_sr;
  logic [31:0] id_sr;
  logic [63:0] ts_sr;

  assign beat     = s_axis_tvalid & s_axis_tkeep;
  assign fin      = s_axis_tvalid & s_axis_tlast;
  assign rx_pos   = int'(idx);
  assign last_hdr = (rx_pos == HDR_LEN - 1);

  // Compare the current header byte; dst tracks unicast and broadcast matches separately
  always_comb begin
    own_ok_nxt = own_ok;
    bc_ok_nxt  = bc_ok;
    byte_ok    = 1'b1;
    if (rx_pos < OFF_SRC) begin
      own_ok_nxt = own_ok & (s_axis_tdata == field_byte({16'h0000, own_mac}, 6, rx_pos - OFF_DST));
      bc_ok_nxt  = bc_ok & (s_axis_tdata == BCAST_MAC[7:0]);
      byte_ok    = own_ok_nxt | bc_ok_nxt;
    end else if (rx_pos >= OFF_TYPE && rx_pos < OFF_MAGIC) begin
      byte_ok = (s_axis_tdata == field_byte({48'h0, C_ETHERTYPE}, 2, rx_pos - OFF_TYPE));
    end else if (rx_pos >= OFF_MAGIC && rx_pos < OFF_ID) begin
      byte_ok = (s_axis_tdata == field_byte({32'h0, PING_MAGIC}, 4, rx_pos - OFF_MAGIC));
    end
  end

  // RX next-state logic; tlast always ends the frame even on a tkeep=0 beat
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    ping_valid = 1'b0;
    case (state)
      RX_HDR: begin
        if (fin) begin
          ping_valid = beat & byte_ok & last_hdr;
          idx_nxt    = '0;
        end else if (beat) begin
          if (!byte_ok) begin
            state_nxt = RX_SKIP;
            idx_nxt   = '0;
          end else if (last_hdr) begin
            state_nxt = RX_TAIL;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      RX_SKIP: begin
        if (fin) begin
          state_nxt = RX_HDR;
          idx_nxt   = '0;
        end
      end
      RX_TAIL: begin
        if (fin) begin
          ping_valid = 1'b1;
          state_nxt  = RX_HDR;
          idx_nxt    = '0;
        end
      end
      default: begin
        state_nxt = RX_HDR;
        idx_nxt   = '0;
      end
    endcase
  end

  // RX state and header index
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_HDR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Dst-match flags restart at every frame boundary
  always_ff @(posedge clk) begin
    if (rst || (state_nxt == RX_HDR && idx_nxt == '0)) begin
      own_ok <= 1'b1;
      bc_ok  <= 1'b1;
    end else if (state == RX_HDR && beat) begin
      own_ok <= own_ok_nxt;
      bc_ok  <= bc_ok_nxt;
    end
  end

  // Shift the echoed fields in as their bytes pass by
  always_ff @(posedge clk) begin
    if (state == RX_HDR && beat) begin
      if (rx_pos >= OFF_SRC && rx_pos < OFF_TYPE) src_sr <= {src_sr[39:0], s_axis_tdata};
      if (rx_pos >= OFF_ID && rx_pos < OFF_TS)    id_sr  <= {id_sr[23:0], s_axis_tdata};
      if (rx_pos >= OFF_TS && rx_pos < HDR_LEN)   ts_sr  <= {ts_sr[55:0], s_axis_tdata};
    end
  end

  // A 30-byte frame ends on its final timestamp byte, which is still on the bus
  assign ping_src = src_sr;
  assign ping_id  = id_sr;
  assign ping_ts  = (state == RX_HDR) ? {ts_sr[55:0], s_axis_tdata} : ts_sr;

endmodule

// File: rtl/eth_ping_responder.sv
// Loopback ping responder: parses pings from the TEMAC RX stream and answers each one
// with a pong on the TX stream, keeping received / sent / dropped statistics.
module eth_ping_responder
  import eth_ping_pkg::*;
#(
  parameter logic [15:0] C_ETHERTYPE = 16'h88B5,
  parameter int          C_PONG_LEN  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [47:0] own_mac,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] pings_received,
  output logic [31:0] pongs_sent,
  output logic [31:0] pings_dropped
);

  localparam int               IDX_W    = $clog2(C_PONG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_PONG_LEN - 1);

  logic        ping_valid;
  logic [47:0] ping_src;
  logic [31:0] ping_id;
  logic [63:0] ping_ts;

  tx_state_t        tx_state, tx_state_nxt;
  logic [IDX_W-1:0] tx_idx, tx_idx_nxt;
  int               tx_pos;
  logic             fire, last_beat, tx_free, latch;
  logic [7:0]       pong_byte;
  logic [47:0]      buf_dst, buf_src;
  logic [31:0]      buf_id;
  logic [63:0]      buf_ts;

  eth_ping_parser #(
    .C_ETHERTYPE (C_ETHERTYPE)
  ) u_parser (
    .clk           (clk),
    .rst           (rst),
    .own_mac       (own_mac),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .ping_valid    (ping_valid),
    .ping_src      (ping_src),
    .ping_id       (ping_id),
    .ping_ts       (ping_ts)
  );

  assign tx_pos    = int'(tx_idx);
  assign fire      = m_axis_tvalid & m_axis_tready;
  assign last_beat = (tx_idx == LAST_IDX);
  // The buffer may be reloaded in the same cycle the previous pong's last byte leaves
  assign tx_free   = (tx_state == TX_IDLE) | (fire & last_beat);
  assign latch     = ping_valid & enable & tx_free;

  // Pong buffer; own_mac is captured so a later change cannot corrupt a queued pong
  always_ff @(posedge clk) begin
    if (latch) begin
      buf_dst <= ping_src;
      buf_src <= own_mac;
      buf_id  <= ping_id;
      buf_ts  <= ping_ts;
    end
  end

  // TX next-state logic
  always_comb begin
    tx_state_nxt = tx_state;
    tx_idx_nxt   = tx_idx;
    case (tx_state)
      TX_IDLE: begin
        if (latch) begin
          tx_state_nxt = TX_SEND;
          tx_idx_nxt   = '0;
        end
      end
      TX_SEND: begin
        if (fire) begin
          if (last_beat) begin
            tx_state_nxt = latch ? TX_SEND : TX_IDLE;
            tx_idx_nxt   = '0;
          end else begin
            tx_idx_nxt = tx_idx + 1'b1;
          end
        end
      end
      default: begin
        tx_state_nxt = TX_IDLE;
        tx_idx_nxt   = '0;
      end
    endcase
  end

  // TX state and byte index
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_idx   <= tx_idx_nxt;
    end
  end

  // Pong byte for the current index; everything past the header is zero padding
  always_comb begin
    pong_byte = 8'h00;
    if (tx_pos < OFF_SRC)
      pong_byte = field_byte({16'h0000, buf_dst}, 6, tx_pos - OFF_DST);
    else if (tx_pos < OFF_TYPE)
      pong_byte = field_byte({16'h0000, buf_src}, 6, tx_pos - OFF_SRC);
    else if (tx_pos < OFF_MAGIC)
      pong_byte = field_byte({48'h0, C_ETHERTYPE}, 2, tx_pos - OFF_TYPE);
    else if (tx_pos < OFF_ID)
      pong_byte = field_byte({32'h0, PONG_MAGIC}, 4, tx_pos - OFF_MAGIC);
    else if (tx_pos < OFF_TS)
      pong_byte = field_byte({32'h0, buf_id}, 4, tx_pos - OFF_ID);
    else if (tx_pos < HDR_LEN)
      pong_byte = field_byte(buf_ts, 8, tx_pos - OFF_TS);
  end

  // Outputs derive from registered state only, so they stay stable across stalls
  assign m_axis_tvalid = (tx_state == TX_SEND);
  assign m_axis_tkeep  = m_axis_tvalid;
  assign m_axis_tlast  = m_axis_tvalid & last_beat;
  assign m_axis_tdata  = m_axis_tvalid ? pong_byte : 8'h00;

  // Statistics counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      pings_received <= '0;
      pongs_sent     <= '0;
      pings_dropped  <= '0;
    end else begin
      if (ping_valid)             pings_received <= pings_received + 32'd1;
      if (fire && last_beat)      pongs_sent     <= pongs_sent + 32'd1;
      if (ping_valid && !latch)   pings_dropped  <= pings_dropped + 32'd1;
    end
  end

endmodule
